// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use/branch hazard control.
// Define ID_EX_PERF_CNT_EN to add saturating StallCount/FlushCount outputs.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [1:0]      ResultSrcD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RA_W-1:0] RdM,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            ValidE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [RA_W-1:0] RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     StallCount,
    output logic [31:0]     FlushCount
`endif
);

    logic            r_valid, r_alusrc, r_regwrite, r_memwrite, r_branch, r_jump;
    logic [2:0]      r_aluctl;
    logic [1:0]      r_resultsrc;
    logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
    logic [RA_W-1:0] r_rs1, r_rs2, r_rd;
    logic            w_lw_stall, w_flush_e;
    logic [XLEN-1:0] w_fwd_a, w_fwd_b;

    assign w_lw_stall = (r_resultsrc == 2'b01) && r_regwrite && (r_rd != '0) &&
                        ((r_rd == Rs1D) || (r_rd == Rs2D));
    assign w_flush_e  = w_lw_stall || PCSrcE;
    assign StallF     = w_lw_stall && !PCSrcE;
    assign StallD     = StallF;
    assign FlushD     = PCSrcE;

    // A flushed E stage takes exactly the reset values, i.e. a bubble.
    always_ff @(posedge clk) begin
        if (reset || w_flush_e) begin
            r_valid     <= 1'b0;
            r_alusrc    <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_aluctl    <= '0;
            r_resultsrc <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pc4       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else begin
            r_valid     <= ValidD;
            r_alusrc    <= ALUSrcD;
            r_regwrite  <= RegWriteD;
            r_memwrite  <= MemWriteD;
            r_branch    <= BranchD;
            r_jump      <= JumpD;
            r_aluctl    <= ALUControlD;
            r_resultsrc <= ResultSrcD;
            r_rd1       <= RD1D;
            r_rd2       <= RD2D;
            r_imm       <= ImmExtD;
            r_pc        <= PCD;
            r_pc4       <= PCPlus4D;
            r_rs1       <= Rs1D;
            r_rs2       <= Rs2D;
            r_rd        <= RdD;
        end
    end

    // MEM result is younger than WB, so it wins when both match.
    assign w_fwd_a = (RegWriteM && (RdM != '0) && (RdM == r_rs1)) ? ALUResultM :
                     (RegWriteW && (RdW != '0) && (RdW == r_rs1)) ? ResultW : r_rd1;
    assign w_fwd_b = (RegWriteM && (RdM != '0) && (RdM == r_rs2)) ? ALUResultM :
                     (RegWriteW && (RdW != '0) && (RdW == r_rs2)) ? ResultW : r_rd2;

    assign SrcAE       = w_fwd_a;
    assign WriteDataE  = w_fwd_b;
    assign SrcBE       = r_alusrc ? r_imm : w_fwd_b;
    assign ValidE      = r_valid;
    assign ALUControlE = r_aluctl;
    assign ImmExtE     = r_imm;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pc4;
    assign RdE         = r_rd;
    assign RegWriteE   = r_regwrite;
    assign MemWriteE   = r_memwrite;
    assign BranchE     = r_branch;
    assign JumpE       = r_jump;
    assign ResultSrcE  = r_resultsrc;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (PCSrcE && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control each cycle, then drives ALUControlE, SrcAE and SrcBE into the ALU during EX.
- Contains the operand forwarding muxes from MEM and WB, and the load-use hazard / branch-flush logic that stalls Fetch/Decode and inserts bubbles into EX.
- One instruction per cycle; 1-cycle latency from D-stage inputs to E-stage outputs.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ValidD  in  1  D-stage holds a real instruction.
- RD1D, RD2D  in  XLEN  register file read data.
- ImmExtD, PCD, PCPlus4D  in  XLEN  immediate, PC, PC+4.
- Rs1D, Rs2D, RdD  in  RA_W  source/destination register addresses.
- ALUControlD  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt).
- ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD  in  1  control.
- ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- ALUResultM, ResultW  in  XLEN  forwarding sources.
- RdM, RdW  in  RA_W; RegWriteM, RegWriteW  in  1.
- StallF, StallD, FlushD  out  1  hazard controls to F/D.
- ValidE  out  1; ALUControlE  out  3; SrcAE, SrcBE, WriteDataE  out  XLEN.
- ImmExtE, PCE, PCPlus4E  out  XLEN; RdE  out  RA_W.
- RegWriteE, MemWriteE, BranchE, JumpE  out  1; ResultSrcE  out  2.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset: every E register is cleared to 0, so the E stage holds a bubble: ValidE=0, RegWriteE=MemWriteE=BranchE=JumpE=0, ResultSrcE=00, ALUControlE=000, and all data and address registers are 0. StallF, StallD and FlushD evaluate to 0 immediately after reset.
- Load-use detection:
  - lwStall = (ResultSrcE==01) & RegWriteE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
  - Matching uses Rs1D/Rs2D regardless of whether the instruction actually reads them; the conservative stall is accepted.
- Hazard outputs (combinational):
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE (internal).
- Register update priority: reset > FlushE (load bubble, identical to the reset values) > normal load of the D inputs.
  - There is no E-side stall; EX always advances.
  - ValidE = ValidD on a normal load.
- Forwarding for operand A (combinational, from E registers):
  - If RegWriteM & RdM!=0 & RdM==Rs1E, select ALUResultM.
  - Else if RegWriteW & RdW!=0 & RdW==Rs1E, select ResultW.
  - Else select RD1E.
  - MEM has priority over WB.
- Forwarding for operand B: identical, using Rs2E and RD2E.
- Operand outputs: SrcAE = forwarded A; WriteDataE = forwarded B; SrcBE = ALUSrcE ? ImmExtE : forwarded B.
- x0 is never forwarded and never triggers a stall.
- Simultaneous PCSrcE and lwStall: E is bubbled, D is flushed, no stall is asserted.
- All arithmetic is XLEN-wide; there are no width extensions inside this block.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds two outputs:
  - StallCount (out, 32): incremented each cycle StallD=1.
  - FlushCount (out, 32): incremented each cycle PCSrcE=1.
- Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
- When not defined, both ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: hold reset high 2 cycles with ValidD=1 and RegWriteD=1 -> ValidE=0, RegWriteE=0, SrcAE=0, StallF=0.
- MEM forward: E holds Rs1E=5, RD1E=0x11; RdM=5, RegWriteM=1, ALUResultM=0x1234; also RdW=5, ResultW=0x99 -> SrcAE=0x1234 (MEM beats WB).
- WB forward on B with immediate: Rs2E=7, RdW=7, RegWriteW=1, ResultW=0xAB, ALUSrcE=1, ImmExtE=0x10 -> SrcBE=0x10, WriteDataE=0xAB.
- Load-use: E = load with RdE=3, D has Rs2D=3 -> StallF=StallD=1 for 1 cycle. Next cycle ValidE=0 and RegWriteE=0, and the D instruction then enters E unchanged.
- Branch flush with concurrent load-use: PCSrcE=1 while lwStall conditions hold -> FlushD=1, StallD=0, next E is a bubble. With ID_EX_PERF_CNT_EN, FlushCount increments by 1 and StallCount is unchanged.
- x0 guard: RdM=0, RegWriteM=1, Rs1E=0, RD1E=0 -> SrcAE=0. A load with RdE=0 and Rs1D=0 -> no stall.
